// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver with a direct-mapped table of 2-bit saturating counters.
// Optional build macro BRANCH_STATS_EN adds resolved-branch and mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 16,
    parameter logic [1:0]  CTR_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            ex_taken,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDXW = $clog2(BHT_DEPTH);

    logic [1:0]      bht_q [BHT_DEPTH];
    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_q, redirect_d;

    logic [IDXW-1:0] if_idx, ex_idx;
    logic            cond_true, resolving;
    logic [1:0]      ctr_cur, ctr_d;

    assign if_idx = if_pc[IDXW+1:2];
    assign ex_idx = ex_pc[IDXW+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDXW+2], if_pc[1:0], ex_pc[1:0]};

    always_comb begin
        cond_true = 1'b0;
        case (ex_funct3)
            3'b000:  cond_true = (ex_rs1 == ex_rs2);
            3'b001:  cond_true = (ex_rs1 != ex_rs2);
            3'b100:  cond_true = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond_true = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond_true = (ex_rs1 <  ex_rs2);
            3'b111:  cond_true = (ex_rs1 >= ex_rs2);
            default: cond_true = 1'b0;
        endcase
    end

    // The instruction in EX during a mispredict pulse is wrong-path and must be ignored.
    assign resolving = ex_valid && ex_branch && (ex_funct3[2:1] != 2'b01) && !mispredict_q;
    assign ex_taken  = resolving && cond_true;

    always_comb begin
        ctr_cur = bht_q[ex_idx];
        ctr_d   = ctr_cur;
        if (ex_taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    always_comb begin
        mispredict_d = resolving && (ex_taken != ex_pred_taken);
        redirect_d   = redirect_q;
        if (mispredict_d) begin
            redirect_d = ex_taken ? ex_target : (ex_pc + XLEN'(4));
        end
    end

    // Reads see the pre-update counter when IF and EX hit the same index.
    assign if_pred_taken = bht_q[if_idx][1];
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                bht_q[i] <= CTR_INIT;
            end
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
        end else begin
            if (resolving) begin
                bht_q[ex_idx] <= ctr_d;
            end
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (resolving)    stat_branches_q    <= stat_branches_q + 32'd1;
            if (mispredict_d) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch unit for the EX stage of the 5-stage RISC-V pipeline. It has two jobs:
- Resolve all six RV32I conditional branches (beq, bne, blt, bge, bltu, bgeu) from the full operand values, rather than from ALU zero/sign flags.
- Keep a direct-mapped table of 2-bit saturating counters. The table gives the IF stage a taken/not-taken prediction and is updated when each branch resolves.

A registered mispredict pulse, together with the redirect PC, drives the IF/ID and ID/EX flush and the PC mux.

## Interface
Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 16, number of counters. Power of two, minimum 2.
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  PC being fetched.
- if_pred_taken  out  1  prediction for if_pc. Combinational, equal to counter[idx(if_pc)][1].
- ex_valid  in  1  EX-stage instruction is valid.
- ex_branch  in  1  EX-stage instruction is a conditional branch.
- ex_funct3  in  3  branch type.
- ex_rs1, ex_rs2  in  XLEN  source operands, already forwarded.
- ex_pc  in  XLEN  PC of the EX-stage branch.
- ex_target  in  XLEN  computed taken target (pc + imm).
- ex_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- ex_taken  out  1  combinational resolved outcome.
- mispredict  out  1  registered one-cycle flush pulse.
- redirect_pc  out  XLEN  registered correct next PC; valid while mispredict = 1.

## Operation
- Index function: idx(pc) = pc[log2(BHT_DEPTH)+1:2].
- A resolving branch requires all of the following:
  - ex_valid & ex_branch,
  - ex_funct3 not in {010, 011},
  - not squashed (see squash rule below).
- Outcome by funct3:
  - 000 eq, 001 ne.
  - 100 signed <, 101 signed >=.
  - 110 unsigned <, 111 unsigned >=.
  - 010/011: ex_taken = 0. No counter update, no mispredict.
- ex_taken is 0 whenever the instruction is not a resolving branch.
- Counter update on a resolving branch, at the clock edge:
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
  - Other counters are unchanged.
- Mispredict detection: a resolving branch with ex_taken != ex_pred_taken. At the next edge:
  - mispredict <= 1,
  - redirect_pc <= ex_taken ? ex_target : ex_pc + 4 (modulo 2^XLEN).
  - Otherwise mispredict <= 0 and redirect_pc holds its value.
- Squash rule: while mispredict = 1, the EX-stage instruction is wrong-path.
  - It is treated as non-resolving: no counter update, ex_taken = 0, no new mispredict.
  - Therefore mispredict is never high on two consecutive cycles.
- Same-index conflict: when if_pc and a resolving ex_pc map to the same index in one cycle, if_pred_taken returns the pre-update value. There is no bypass.

## Timing
- Prediction: 0-cycle combinational read.
- Resolution: ex_taken is combinational.
- Mispredict and redirect_pc: 1-cycle latency from the EX cycle, high for exactly 1 cycle.
- Counter write: effective from the cycle after resolution.
- Reset, at the first edge with reset = 1:
  - all counters = CTR_INIT,
  - mispredict = 0,
  - redirect_pc = 0,
  - stats counters = 0.
- Reset overrides any simultaneous update or mispredict. A pending mispredict is dropped.
- Outputs while reset is held:
  - if_pred_taken = CTR_INIT[1],
  - ex_taken follows its inputs.

## Configuration
- BRANCH_STATS_EN defined:
  - adds output ports stat_branches [31:0] and stat_mispredicts [31:0],
  - stat_branches increments on every resolving branch,
  - stat_mispredicts increments on every detected mispredict,
  - both wrap at 2^32 and clear on reset.
- BRANCH_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset followed by a lookup:
  - reset high 2 cycles, then if_pc = 0x40 -> if_pred_taken = 0.
  - Two taken resolutions at ex_pc = 0x40 -> if_pred_taken = 1 two cycles after the first.
- Signed vs unsigned comparison:
  - rs1 = 0xFFFFFFFF, rs2 = 1.
  - funct3 100 -> ex_taken = 1. funct3 110 -> ex_taken = 0. funct3 111 -> ex_taken = 1.
- Mispredict pulse:
  - beq, rs1 = rs2 = 5, ex_pred_taken = 0, ex_target = 0x200, ex_pc = 0x100.
  - Next cycle: mispredict = 1, redirect_pc = 0x200. The cycle after: mispredict = 0.
- Squash and not-taken redirect:
  - bne, rs1 = 3, rs2 = 3, ex_pred_taken = 1, ex_pc = 0xFFFFFFFC -> redirect_pc = 0x00000000.
  - A mispredicting branch presented in the pulse cycle -> no second pulse and its counter unchanged.
- Saturation and invalid funct3:
  - Five taken resolutions on one index, then one not-taken -> prediction still 1 (counter 10).
  - funct3 = 010 -> no update, no mispredict.
- Stats (BRANCH_STATS_EN defined):
  - 10 resolving branches, 3 of them mispredicting -> stat_branches = 10, stat_mispredicts = 3.
  - Mid-run reset -> both 0.
